trng_arbiter: RTL and testbench

Shares the single TRNG word source between NUM_REQ independent consumers, e.g. a key generator, masking logic and the Wishbone read path. It sits between the TRNG Wishbone wrapper's valid/buffer outputs and the consumers. It discards a configurable number of start-up words, holds one fresh word and grants it to exactly one requester in round-robin order. Every delivered word is consumed exactly once and is never reused.

---
 rtl/trng_pkg.sv | 13 +
 rtl/rr_arbiter_onehot.sv | 41 ++++
 rtl/trng_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_trng_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trng_pkg.sv
// Shared types and widths for the TRNG word arbiter.
package trng_pkg;

    typedef enum logic [1:0] {
        S_WARMUP = 2'd0,
        S_EMPTY  = 2'd1,
        S_FULL   = 2'd2
    } trng_state_e;

    localparam int STARVE_W     = 16;
    localparam int WARMUP_CNT_W = 4;

endpackage

// File: rtl/rr_arbiter_onehot.sv
// Combinational round-robin search: first request at or above ptr, wrapping.
// Returns a one-hot grant, the granted index and a found flag.
module rr_arbiter_onehot #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    localparam int PW = IDX_W + 1;

    logic [IDX_W:0] pos;

    // Walk upward from the pointer with wrap-around; the first set request wins.
    always_comb begin
        idx = '0;
        any = 1'b0;
        pos = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = {1'b0, ptr} + PW'(k);
            if (pos >= PW'(NUM_REQ)) begin
                pos = pos - PW'(NUM_REQ);
            end
            if (!any && req[pos[IDX_W-1:0]]) begin
                any = 1'b1;
                idx = pos[IDX_W-1:0];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
            assign gnt[gi] = any && (idx == IDX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/trng_arbiter.sv
// Shares one TRNG word source between NUM_REQ consumers in round-robin order.
// Drops WARMUP_WORDS start-up words, then holds one word at a time and hands
// it to exactly one requester. Optional macro TRNG_HEALTH_EN adds a
// repetition test and the sticky health_fail_o output.
module trng_arbiter
    import trng_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int WORD_W        = 32,
    parameter int WARMUP_WORDS  = 4,
    parameter int STARVE_CYCLES = 1023
) (
    input  logic               wb_clk_i,
    input  logic               rst_ni,
    input  logic               trng_valid_i,
    input  logic [WORD_W-1:0]  trng_word_i,
    output logic               trng_ack_o,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [WORD_W-1:0]  rnd_o,
    output logic               warm_o,
    output logic               starve_o,
    input  logic               starve_clr_i
`ifdef TRNG_HEALTH_EN
    ,
    output logic               health_fail_o
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam trng_state_e RESET_STATE = (WARMUP_WORDS == 0) ? S_EMPTY : S_WARMUP;
    localparam logic [WARMUP_CNT_W-1:0] WARMUP_TARGET = WARMUP_CNT_W'(WARMUP_WORDS);
    localparam logic [STARVE_W-1:0]     STARVE_LIMIT  = STARVE_W'(STARVE_CYCLES);
    localparam logic [STARVE_W-1:0]     STARVE_MAX    = '1;

    trng_state_e             state_reg, state_next;
    logic [WORD_W-1:0]       hold_reg, hold_next;
    logic [IDX_W-1:0]        ptr_reg, ptr_next;
    logic [WARMUP_CNT_W-1:0] warm_cnt_reg, warm_cnt_next;
    logic [STARVE_W-1:0]     starve_cnt_reg, starve_cnt_next;
    logic                    ack_reg, ack_next;
    logic [NUM_REQ-1:0]      gnt_reg, gnt_next;
    logic [WORD_W-1:0]       rnd_reg, rnd_next;
    logic                    warm_reg, warm_next;
    logic                    starve_reg, starve_next;

    logic                    take;
    logic                    repeat_hit;
    logic                    grant_hold;
    logic [NUM_REQ-1:0]      arb_gnt;
    logic [IDX_W-1:0]        arb_idx;
    logic                    arb_any;

    // A source word may only be taken when the previous cycle did not ack,
    // which gives the source one cycle to drop valid.
    assign take = trng_valid_i && !ack_reg;

    rr_arbiter_onehot #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req (req_i),
        .ptr (ptr_reg),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

`ifdef TRNG_HEALTH_EN
    logic [WORD_W-1:0] last_reg;
    logic              last_valid_reg;
    logic [1:0]        rep_cnt_reg;
    logic              health_fail_reg;

    assign repeat_hit    = last_valid_reg && (trng_word_i == last_reg);
    assign grant_hold    = health_fail_reg;
    assign health_fail_o = health_fail_reg;

    // Repetition test on every word taken, warm-up words included; three
    // consecutive repeats latch the failure until reset.
    always_ff @(posedge wb_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_reg        <= '0;
            last_valid_reg  <= 1'b0;
            rep_cnt_reg     <= '0;
            health_fail_reg <= 1'b0;
        end else if (ack_next) begin
            last_reg       <= trng_word_i;
            last_valid_reg <= 1'b1;
            if (repeat_hit) begin
                if (rep_cnt_reg != 2'd3) begin
                    rep_cnt_reg <= rep_cnt_reg + 2'd1;
                end
                if (rep_cnt_reg == 2'd2) begin
                    health_fail_reg <= 1'b1;
                end
            end else begin
                rep_cnt_reg <= '0;
            end
        end
    end
`else
    assign repeat_hit = 1'b0;
    assign grant_hold = 1'b0;
`endif

    // State and output registers; every output is registered.
    always_ff @(posedge wb_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg      <= RESET_STATE;
            hold_reg       <= '0;
            ptr_reg        <= '0;
            warm_cnt_reg   <= '0;
            starve_cnt_reg <= '0;
            ack_reg        <= 1'b0;
            gnt_reg        <= '0;
            rnd_reg        <= '0;
            warm_reg       <= 1'b0;
            starve_reg     <= 1'b0;
        end else begin
            state_reg      <= state_next;
            hold_reg       <= hold_next;
            ptr_reg        <= ptr_next;
            warm_cnt_reg   <= warm_cnt_next;
            starve_cnt_reg <= starve_cnt_next;
            ack_reg        <= ack_next;
            gnt_reg        <= gnt_next;
            rnd_reg        <= rnd_next;
            warm_reg       <= warm_next;
            starve_reg     <= starve_next;
        end
    end

    // Next-state: drop warm-up words, refill when empty, grant when full.
    always_comb begin
        state_next    = state_reg;
        hold_next     = hold_reg;
        ptr_next      = ptr_reg;
        warm_cnt_next = warm_cnt_reg;
        ack_next      = 1'b0;
        gnt_next      = '0;
        rnd_next      = '0;
        case (state_reg)
            S_WARMUP: begin
                if (take) begin
                    ack_next      = 1'b1;
                    warm_cnt_next = warm_cnt_reg + WARMUP_CNT_W'(1);
                    if (warm_cnt_next == WARMUP_TARGET) begin
                        state_next = S_EMPTY;
                    end
                end
            end
            S_EMPTY: begin
                if (take) begin
                    ack_next = 1'b1;
                    // A repeated word is consumed from the source but never held.
                    if (!repeat_hit) begin
                        hold_next  = trng_word_i;
                        state_next = S_FULL;
                    end
                end
            end
            S_FULL: begin
                if (arb_any && !grant_hold) begin
                    gnt_next   = arb_gnt;
                    rnd_next   = hold_reg;
                    hold_next  = '0;
                    ptr_next   = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
                    state_next = S_EMPTY;
                end
            end
            default: begin
                state_next = RESET_STATE;
            end
        endcase
        warm_next = warm_reg || (state_next != S_WARMUP);
    end

    // Starvation watch: count waiting cycles without a held word; clear wins over set.
    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (starve_clr_i || (req_i == '0) || (gnt_next != '0)) begin
            starve_cnt_next = '0;
        end else if ((state_reg != S_FULL) && (starve_cnt_reg != STARVE_MAX)) begin
            starve_cnt_next = starve_cnt_reg + STARVE_W'(1);
        end
        starve_next = starve_clr_i ? 1'b0 : (starve_reg || (starve_cnt_next >= STARVE_LIMIT));
    end

    assign trng_ack_o = ack_reg;
    assign gnt_o      = gnt_reg;
    assign rnd_o      = rnd_reg;
    assign warm_o     = warm_reg;
    assign starve_o   = starve_reg;

endmodule

// File: tb/tb_trng_arbiter.sv
// Self-checking bench for trng_arbiter: grant-order vector table, scoreboard
// of delivered words, and hand sequences for warm-up, hold, drop, starve,
// and reset corner cases.
module tb_trng_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        valid = 1'b0;
    logic [31:0] word = '0;
    logic        ack;
    logic [3:0]  req = '0;
    logic [3:0]  gnt;
    logic [31:0] rnd;
    logic        warm;
    logic        starve;
    logic        clr = 1'b0;
`ifdef TRNG_HEALTH_EN
    logic        health_fail;
`endif

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          ack_cnt = 0;
    int          gnt_cnt = 0;
    int          warm_left = 4;
    int          last_ack_cyc = 0;
    int          ack_gap = 0;
    int          last_gnt_cyc = 0;
    int          gnt_gap = 0;
    bit          prev_ack = 1'b0;
    logic [3:0]  prev_gnt = '0;
    bit          health_mode = 1'b0;
    bit          have_last = 1'b0;
    logic [31:0] last_word = '0;
    logic [15:0] seq = '0;
    logic [31:0] sb[$];

    typedef struct {
        logic [3:0] req;
        logic [3:0] exp_gnt;
    } vec_t;

    vec_t        tbl[10];

    trng_arbiter #(
        .NUM_REQ       (4),
        .WORD_W        (32),
        .WARMUP_WORDS  (4),
        .STARVE_CYCLES (20)
    ) dut (
        .wb_clk_i     (clk),
        .rst_ni       (rst_n),
        .trng_valid_i (valid),
        .trng_word_i  (word),
        .trng_ack_o   (ack),
        .req_i        (req),
        .gnt_o        (gnt),
        .rnd_o        (rnd),
        .warm_o       (warm),
        .starve_o     (starve),
        .starve_clr_i (clr)
`ifdef TRNG_HEALTH_EN
        ,
        .health_fail_o (health_fail)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] next_word();
        seq = seq + 16'd1;
        return {seq ^ 16'h5A5A, seq};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // One clock: sample outputs 1 time unit after the edge, check the
    // handshake rules, score grants, and refill the source on every ack.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        checks++;
        if ((ack && prev_ack) || (ack && (gnt != '0)) || ((gnt != '0) && (prev_gnt != '0)) ||
            ($countones(gnt) > 1) || ((gnt == '0) && (rnd != '0))) begin
            errors++;
            $display("FAIL protocol: ack=%b prev_ack=%b gnt=%b prev_gnt=%b rnd=%h cycle %0d",
                     ack, prev_ack, gnt, prev_gnt, rnd, cyc);
        end
        if (gnt != '0) begin
            $display("grant gnt=%b rnd=%h cycle %0d", gnt, rnd, cyc);
            gnt_cnt++;
            gnt_gap = cyc - last_gnt_cyc;
            last_gnt_cyc = cyc;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty: got grant rnd=%h, required no grant", rnd);
            end else begin
                check("rnd_word", 64'(rnd), 64'(sb.pop_front()));
            end
        end
        if (ack) begin
            ack_cnt++;
            ack_gap = cyc - last_ack_cyc;
            last_ack_cyc = cyc;
            if (warm_left > 0) begin
                warm_left--;
            end else if (!(health_mode && have_last && (word == last_word))) begin
                sb.push_back(word);
            end
            last_word = word;
            have_last = 1'b1;
            word = (health_mode && (warm_left == 0)) ? 32'hDEADBEEF : next_word();
        end
        prev_ack = ack;
        prev_gnt = gnt;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb.delete();
        warm_left = 4;
        ack_cnt = 0;
        gnt_cnt = 0;
        have_last = 1'b0;
        prev_ack = 1'b0;
        prev_gnt = '0;
        #1;
        check("reset_outputs", 64'({ack, gnt, rnd, warm, starve}), 64'(0));
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_grant(input int budget, output logic [3:0] g);
        int base = gnt_cnt;
        g = '0;
        for (int i = 0; i < budget && gnt_cnt == base; i++) begin
            step();
        end
        if (gnt_cnt == base) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout: got no grant in %0d cycles, required one", budget);
        end else begin
            g = gnt;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  g;
        logic [31:0] old_word;
        int          ab;
        int          gb;

        tbl = '{'{4'b1111, 4'b0001}, '{4'b1111, 4'b0010}, '{4'b1111, 4'b0100},
                '{4'b1111, 4'b1000}, '{4'b1111, 4'b0001}, '{4'b0010, 4'b0010},
                '{4'b0011, 4'b0001}, '{4'b0011, 4'b0010}, '{4'b1010, 4'b1000},
                '{4'b1010, 4'b0010}};

        word = next_word();
        #3;

        // Warm-up: four dropped words two cycles apart, then req0 gets the fifth.
        valid = 1'b1;
        req   = 4'b0001;
        do_reset();
        for (int i = 0; i < 40 && gnt_cnt == 0; i++) begin
            step();
            if (ack && ack_cnt <= 5) begin
                if (ack_cnt > 1) check("warm_ack_gap", 64'(ack_gap), 64'(2));
                if (ack_cnt <= 3) check("warm_low", 64'(warm), 64'(0));
                if (ack_cnt == 5) check("warm_high", 64'(warm), 64'(1));
            end
        end
        check("first_grant", 64'(gnt), 64'(4'b0001));
        check("acks_before_grant", 64'(ack_cnt), 64'(5));

        // Round-robin order from a fresh pointer, then pointer-relative cases.
        req = tbl[0].req;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            req = tbl[i].req;
            wait_grant(40, g);
            check($sformatf("tbl_gnt[%0d]", i), 64'(g), 64'(tbl[i].exp_gnt));
            if (i > 0) check($sformatf("tbl_gap[%0d]", i), 64'(gnt_gap >= 2), 64'(1));
        end

        // Word held indefinitely with no request; exactly one refill.
        req = 4'b0000;
        ab = ack_cnt;
        gb = gnt_cnt;
        repeat (10) step();
        check("hold_acks", 64'(ack_cnt - ab), 64'(1));
        check("hold_no_gnt", 64'(gnt_cnt - gb), 64'(0));
        req = 4'b0100;
        wait_grant(5, g);
        check("hold_then_gnt", 64'(g), 64'(4'b0100));

        // Request dropped while empty is never granted.
        valid = 1'b0;
        req   = 4'b0010;
        repeat (3) step();
        req   = 4'b0000;
        valid = 1'b1;
        ab = ack_cnt;
        gb = gnt_cnt;
        repeat (10) step();
        check("drop_acks", 64'(ack_cnt - ab), 64'(1));
        check("drop_no_gnt", 64'(gnt_cnt - gb), 64'(0));
        req = 4'b1000;
        wait_grant(5, g);
        check("drop_then_gnt", 64'(g), 64'(4'b1000));

        // Starvation: flag at exactly 20 waiting cycles, clear, clear beats set.
        valid = 1'b0;
        req   = 4'b0100;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 19) check("starve_19", 64'(starve), 64'(0));
            if (i == 20) check("starve_20", 64'(starve), 64'(1));
        end
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("starve_clr", 64'(starve), 64'(0));
        repeat (19) step();
        check("starve_recount", 64'(starve), 64'(0));
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("starve_clr_wins", 64'(starve), 64'(0));
        step();
        check("starve_after_tie", 64'(starve), 64'(0));

        // Reset while full: held word lost, warm-up restarts.
        req   = 4'b0000;
        valid = 1'b1;
        ab = ack_cnt;
        for (int i = 0; i < 10 && ack_cnt == ab; i++) step();
        check("full_setup_ack", 64'(ack_cnt - ab), 64'(1));
        old_word = last_word;
        repeat (2) step();
        do_reset();
        req = 4'b0001;
        wait_grant(40, g);
        check("post_reset_gnt", 64'(g), 64'(4'b0001));
        check("post_reset_acks", 64'(ack_cnt), 64'(5));
        check("no_stale_word", 64'(rnd != old_word), 64'(1));

`ifdef TRNG_HEALTH_EN
        // Repeated 0xDEADBEEF: first grantable, three repeats latch the failure.
        health_mode = 1'b1;
        req = 4'b0001;
        do_reset();
        wait_grant(40, g);
        check("health_first_gnt", 64'(g), 64'(4'b0001));
        check("health_first_word", 64'(rnd), 64'(32'hDEADBEEF));
        check("health_ok_first", 64'(health_fail), 64'(0));
        gb = gnt_cnt;
        repeat (20) step();
        check("health_fail_set", 64'(health_fail), 64'(1));
        check("health_repeats_no_gnt", 64'(gnt_cnt - gb), 64'(0));
        health_mode = 1'b0;
        gb = gnt_cnt;
        repeat (20) step();
        check("health_blocks_gnt", 64'(gnt_cnt - gb), 64'(0));
        check("health_sticky", 64'(health_fail), 64'(1));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
